// File: rtl/demux_4_out.sv
// demux_4_out: 1-to-4 registered demultiplexer with a single-entry holding register per output lane.
// Define DEMUX_CNT_EN to add saturating per-lane delivery counters (cnt_clr, cnt0..cnt3).
module demux_4_out #(
    parameter int DATA_W = 64
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3
`ifdef DEMUX_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
`endif
);

    logic [DATA_W-1:0] lane_data [4];
    logic [3:0]        lane_valid;
    logic              accept;
    logic [3:0]        accept_lane;
    logic [3:0]        transfer;

    // Only the selected lane can stall the input; a full lane being drained this cycle still accepts.
    assign in_ready    = !lane_valid[in_sel] || out_ready[in_sel];
    assign accept      = in_valid && in_ready;
    assign accept_lane = accept ? (4'b0001 << in_sel) : 4'b0000;
    assign transfer    = lane_valid & out_ready;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lane_data[i]  <= '0;
                lane_valid[i] <= 1'b0;
            end else if (accept_lane[i]) begin
                lane_data[i]  <= in_data;
                lane_valid[i] <= 1'b1;
            end else if (transfer[i]) begin
                lane_valid[i] <= 1'b0;
            end
        end
    end

    assign out_valid = lane_valid;
    assign out_data0 = lane_data[0];
    assign out_data1 = lane_data[1];
    assign out_data2 = lane_data[2];
    assign out_data3 = lane_data[3];

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] lane_cnt [4];

    // Clear has priority over a same-cycle transfer; counts stick at all-ones.
    for (genvar i = 0; i < 4; i++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lane_cnt[i] <= '0;
            end else if (cnt_clr) begin
                lane_cnt[i] <= '0;
            end else if (transfer[i] && (lane_cnt[i] != '1)) begin
                lane_cnt[i] <= lane_cnt[i] + 1'b1;
            end
        end
    end

    assign cnt0 = lane_cnt[0];
    assign cnt1 = lane_cnt[1];
    assign cnt2 = lane_cnt[2];
    assign cnt3 = lane_cnt[3];
`endif

endmodule

// File: tb/tb_demux_4_out.sv
// Self-checking bench for demux_4_out: per-lane scoreboard queues plus directed and random steps.
// With DEMUX_CNT_EN defined the DUT is built with CNT_W=2 and the counters are checked too.
module tb_demux_4_out;

    localparam int DATA_W   = 64;
    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [DATA_W-1:0] out_data3;
`ifdef DEMUX_CNT_EN
    logic                cnt_clr;
    logic [TB_CNT_W-1:0] cnt0;
    logic [TB_CNT_W-1:0] cnt1;
    logic [TB_CNT_W-1:0] cnt2;
    logic [TB_CNT_W-1:0] cnt3;
    int                  exp_cnt [4];
`endif

    int                checks;
    int                failures;
    logic [DATA_W-1:0] lane_q [4][$];
    logic [DATA_W-1:0] last_data [4];

`ifdef DEMUX_CNT_EN
    demux_4_out #(.DATA_W(DATA_W), .CNT_W(TB_CNT_W)) dut (
`else
    demux_4_out #(.DATA_W(DATA_W)) dut (
`endif
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] observed, input logic [DATA_W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] lane_out(input int i);
        case (i)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

`ifdef DEMUX_CNT_EN
    function automatic logic [TB_CNT_W-1:0] lane_cnt(input int i);
        case (i)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            default: return cnt3;
        endcase
    endfunction
`endif

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (lane_q[i].size() != 0);
        return v;
    endfunction

    // One clock: check in_ready, score transfers and accepts, advance, then check every lane.
    task automatic step();
        int   s;
        logic exp_ready;
        logic [3:0] xfer;
        #1;
        s = int'(in_sel);
        xfer = 4'b0000;
        exp_ready = (lane_q[s].size() == 0) || out_ready[s];
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        for (int i = 0; i < 4; i++) begin
            if (lane_q[i].size() != 0 && out_ready[i]) begin
                check($sformatf("xfer_data%0d", i), lane_out(i), lane_q[i][0]);
                void'(lane_q[i].pop_front());
                xfer[i] = 1'b1;
            end
        end
        if (in_valid && exp_ready) begin
            lane_q[s].push_back(in_data);
            last_data[s] = in_data;
        end
`ifdef DEMUX_CNT_EN
        for (int i = 0; i < 4; i++) begin
            if (cnt_clr) exp_cnt[i] = 0;
            else if (xfer[i] && exp_cnt[i] < CNT_MAX) exp_cnt[i]++;
        end
`endif
        @(posedge clk);
        #1;
        check("out_valid", {60'd0, out_valid}, {60'd0, exp_valid()});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("out_data%0d", i), lane_out(i), last_data[i]);
`ifdef DEMUX_CNT_EN
            check($sformatf("cnt%0d", i), {62'd0, lane_cnt(i)}, DATA_W'(exp_cnt[i]));
`endif
        end
    endtask

    task automatic drive(input logic v, input int sel, input logic [DATA_W-1:0] d, input logic [3:0] rdy);
        in_valid  = v;
        in_sel    = 2'(sel);
        in_data   = d;
        out_ready = rdy;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            lane_q[i].delete();
            last_data[i] = '0;
`ifdef DEMUX_CNT_EN
            exp_cnt[i] = 0;
`endif
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_model();
        reset = 1'b1;
        drive(1'b0, 0, '0, 4'b0000);
`ifdef DEMUX_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {60'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 4; i++) check($sformatf("rst_data%0d", i), lane_out(i), '0);
        #3;
        reset = 1'b0;

        // Asynchronous reset mid-cycle discards a held word.
        drive(1'b1, 2, 64'hAA, 4'b0000);
        step();
        drive(1'b0, 0, '0, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {60'd0, out_valid}, 64'd0);
        check("async_rst_data2", out_data2, 64'd0);
        clear_model();
        #2;
        reset = 1'b0;
        repeat (3) step();

        // Single route, held stable, then drained.
        drive(1'b1, 2, 64'h1234_5678_9ABC_DEF0, 4'b0000);
        step();
        drive(1'b0, 0, '0, 4'b0000);
        repeat (5) step();
        check("route_valid", {60'd0, out_valid}, 64'h4);
        drive(1'b0, 0, '0, 4'b0100);
        step();
        check("route_drained", {60'd0, out_valid}, 64'h0);

        // Backpressure on lane1 must not block lane3.
        drive(1'b1, 1, 64'h11, 4'b0000);
        step();
        drive(1'b1, 1, 64'h22, 4'b0000);
        step();
        check("bp_data1", out_data1, 64'h11);
        drive(1'b1, 3, 64'h33, 4'b0000);
        step();
        check("bp_data3", out_data3, 64'h33);
        drive(1'b0, 0, '0, 4'b1111);
        step();

        // Full throughput, 8 words cycling through the lanes.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, (k - 1) % 4, DATA_W'(k), 4'b1111);
            step();
        end
        drive(1'b0, 0, '0, 4'b1111);
        step();

        // Drain and refill lane0 in the same cycle.
        drive(1'b1, 0, 64'h5, 4'b0000);
        step();
        drive(1'b1, 0, 64'h6, 4'b0001);
        step();
        check("refill_data0", out_data0, 64'h6);
        drive(1'b0, 0, '0, 4'b1111);
        step();

`ifdef DEMUX_CNT_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 3, DATA_W'(64'h300 + k), 4'b1000);
            step();
        end
        check("cnt3_sat", {62'd0, cnt3}, 64'd3);
        cnt_clr = 1'b1;
        drive(1'b0, 0, '0, 4'b1000);
        step();
        check("cnt3_clr", {62'd0, cnt3}, 64'd0);
        cnt_clr = 1'b0;
`endif

        // Random traffic with random backpressure.
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 4'($urandom_range(0, 15)));
`ifdef DEMUX_CNT_EN
            cnt_clr = ($urandom_range(0, 15) == 0);
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_4_out.md
Name: demux_4_out

Overview:
- 1-to-4 registered demultiplexer for 64-bit words. It is the distributing counterpart of the 4-input selector used in the datapath.
- Takes one valid/ready input stream and steers each accepted word to one of four output lanes chosen by a 2-bit select.
- Each lane owns a single-entry holding register with its own valid/ready handshake.
- Sits between a single producer (e.g. writeback/result bus) and four independent consumers.

Parameters:
DATA_W, 64, width of data words on input and every output lane
CNT_W, 16, width of per-lane delivery counters (used only when DEMUX_CNT_EN is defined)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input word present
in_ready  output  1  block can accept the input word this cycle
in_sel  input  2  destination lane for in_data (00→lane0 … 11→lane3)
in_data  input  DATA_W  input word
out_valid  output  4  bit i: lane i holds a word
out_ready  input  4  bit i: consumer i takes lane i word this cycle
out_data0..out_data3  output  DATA_W each  lane 0..3 held word
cnt_clr  input  1  synchronous clear of delivery counters (DEMUX_CNT_EN only)
cnt0..cnt3  output  CNT_W each  lane 0..3 delivered-word counts (DEMUX_CNT_EN only)

Behaviour:
- Reset (async, active-high, takes effect immediately regardless of clk):
  - out_valid = 4'b0000, out_data0..3 = 0, counters = 0.
  - Words held at reset are discarded. Nothing is delivered after reset deasserts until a new input accept.
- in_ready is combinational: in_ready = !out_valid[in_sel] || out_ready[in_sel]. It depends only on the selected lane; other lanes never block the input.
- Input accept: in_valid && in_ready at a rising edge.
- Output transfer on lane i: out_valid[i] && out_ready[i] at a rising edge.
- Lane i next state, per edge:
  - accept to lane i (with or without transfer on lane i): data_i <= in_data, valid_i <= 1. Drain and refill in the same cycle is a full-throughput pass, 1 word/cycle.
  - transfer on lane i, no accept to i: valid_i <= 0, data_i holds its value.
  - neither: hold.
- Latency: word accepted at edge N is visible on out_data[in_sel] with out_valid high from edge N (registered output), i.e. 1 cycle after presentation.
- Stability: while out_valid[i] && !out_ready[i], out_data_i and out_valid[i] must not change.
- in_sel and in_data are don't-care while in_valid=0. No lane changes on a non-accepted cycle.
- Lanes are fully independent. Simultaneous transfers on any subset of lanes are allowed in the same cycle as an accept to any lane.
- Ordering is preserved per lane only. There is no cross-lane ordering guarantee.
- out_ready[i] asserted while out_valid[i]=0 has no effect.
- No data is ever dropped or duplicated. Each accepted word is presented on exactly one lane until transferred.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - Adds cnt_clr and cnt0..cnt3. cnt_i increments by 1 on each lane-i output transfer.
  - Saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets all counters to 0 at the edge. If a transfer occurs in the same cycle, clear wins and the counter is 0.
  - Counters reset to 0.
- Not defined: cnt_clr and cnt0..cnt3 ports and all counter logic are absent. Datapath behaviour is identical.

Test Plan:
- Reset then idle: reset=1 mid-cycle with lane2 holding 64'hAA → out_valid goes 0000 immediately; after release, out_valid stays 0000 with in_valid=0.
- Single route: in_sel=2, in_data=64'h1234_5678_9ABC_DEF0, out_ready=0 → after 1 edge out_valid=0100, out_data2=that value, held stable for 5 cycles; then out_ready[2]=1 → out_valid=0000 next edge.
- Backpressure: lane1 full, out_ready[1]=0, in_sel=1 → in_ready=0, out_data1 unchanged. Switch in_sel=3 with same state → in_ready=1, word lands on lane3.
- Throughput: out_ready=1111, 8 back-to-back words, in_sel cycling 0..3, data=1..8 → in_ready=1 every cycle, each lane shows its two words in order, one per cycle.
- Simultaneous drain/fill: lane0 holds 64'h5, out_ready[0]=1, new accept to lane0 with 64'h6 → out_valid[0] stays 1, out_data0=64'h6 next edge.
- DEMUX_CNT_EN, CNT_W=2: 5 transfers on lane3 → cnt3 = 3 (saturated). cnt_clr together with a transfer → cnt3 = 0.
